// File: rtl/mix_fifo_rd_pkg.sv
// rtl/mix_fifo_rd_pkg.sv - shared FSM state type, default pack ratio and lane-counter width helper
package mix_fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } rd_state_e;

    localparam int PACK = 64 / 16;

    function automatic int lane_cnt_w(input int pack);
        return (pack > 1) ? $clog2(pack) : 1;
    endfunction

endpackage

// File: rtl/mix_fifo_rd_packer.sv
// rtl/mix_fifo_rd_packer.sv - pixel lane register, lane counter and beat-completion detection
module mix_fifo_rd_packer
    import mix_fifo_rd_pkg::*;
#(
    parameter int IN_W = 16,
    parameter int PK   = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  logic               line_end_i,
    input  logic [IN_W-1:0]    pix_i,
    output logic               complete_o,
    output logic [PK*IN_W-1:0] beat_o
);

    localparam int LW = lane_cnt_w(PK);

    logic [LW-1:0]            lane_cnt_q;
    logic [PK-2:0][IN_W-1:0]  lane_q;

    assign complete_o = (lane_cnt_q == LW'(PK - 1)) || line_end_i;

    // Lanes above the current one are forced to zero, so a short line-end beat needs no lane clearing.
    always_comb begin
        beat_o = '0;
        for (int i = 0; i < PK - 1; i++) begin
            if (i < int'(lane_cnt_q)) begin
                beat_o[i*IN_W +: IN_W] = lane_q[i];
            end
        end
        for (int i = 0; i < PK; i++) begin
            if (i == int'(lane_cnt_q)) begin
                beat_o[i*IN_W +: IN_W] = pix_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lane_cnt_q <= '0;
            lane_q     <= '0;
        end else if (push_i) begin
            if (complete_o) begin
                lane_cnt_q <= '0;
            end else begin
                for (int i = 0; i < PK - 1; i++) begin
                    if (i == int'(lane_cnt_q)) begin
                        lane_q[i] <= pix_i;
                    end
                end
                lane_cnt_q <= lane_cnt_q + LW'(1);
            end
        end
    end

endmodule

// File: rtl/mix_fifo_burst_reader.sv
// rtl/mix_fifo_burst_reader.sv - FIFO read-side burst packer; MIX_FIFO_RD_STAT_EN adds stall_cnt
// Frame/line FSM, counters and the one-deep output beat register.
module mix_fifo_burst_reader
    import mix_fifo_rd_pkg::*;
#(
    parameter int IN_DATA_WIDTH  = 16,
    parameter int OUT_DATA_WIDTH = 64,
    parameter int BURST_LEN      = 16,
    parameter int CNT_WIDTH      = 12
) (
    input  logic                      rd_clk,
    input  logic                      rd_rst,
    input  logic                      frame_start,
    input  logic [CNT_WIDTH-1:0]      cfg_line_pixels,
    input  logic [CNT_WIDTH-1:0]      cfg_lines,
    input  logic                      fifo_rd_vld,
    input  logic [IN_DATA_WIDTH-1:0]  fifo_rd_data,
    output logic                      fifo_rd_en,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [OUT_DATA_WIDTH-1:0] m_data,
    output logic                      m_last,
    output logic                      m_eol,
    output logic                      busy,
    output logic                      done
`ifdef MIX_FIFO_RD_STAT_EN
    ,
    output logic [31:0]               stall_cnt
`endif
);

    localparam int PK = OUT_DATA_WIDTH / IN_DATA_WIDTH;
    localparam int BW = $clog2(BURST_LEN);

    rd_state_e                 state_q;
    logic [CNT_WIDTH-1:0]      line_pix_q;
    logic [CNT_WIDTH-1:0]      lines_q;
    logic [CNT_WIDTH-1:0]      pix_cnt_q;
    logic [CNT_WIDTH-1:0]      line_cnt_q;
    logic [BW-1:0]             beat_cnt_q;
    logic                      m_valid_q;
    logic [OUT_DATA_WIDTH-1:0] m_data_q;
    logic                      m_last_q;
    logic                      m_eol_q;
    logic                      busy_q;
    logic                      done_q;

    logic                      line_end_d;
    logic                      last_line_d;
    logic                      complete_d;
    logic                      pop_d;
    logic                      last_beat_d;
    logic [OUT_DATA_WIDTH-1:0] beat_d;

    assign line_end_d  = (pix_cnt_q == line_pix_q - CNT_WIDTH'(1));
    assign last_line_d = (line_cnt_q == lines_q - CNT_WIDTH'(1));
    assign last_beat_d = (beat_cnt_q == BW'(BURST_LEN - 1)) || line_end_d;

    // A pixel that only fills a lane can always be taken; one that finishes a beat needs the output slot.
    assign pop_d = (state_q == RUN) && fifo_rd_vld && (!complete_d || !m_valid_q || m_ready);

    mix_fifo_rd_packer #(
        .IN_W (IN_DATA_WIDTH),
        .PK   (PK)
    ) u_packer (
        .clk_i      (rd_clk),
        .rst_i      (rd_rst),
        .push_i     (pop_d),
        .line_end_i (line_end_d),
        .pix_i      (fifo_rd_data),
        .complete_o (complete_d),
        .beat_o     (beat_d)
    );

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_q    <= IDLE;
            line_pix_q <= '0;
            lines_q    <= '0;
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            beat_cnt_q <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_last_q   <= 1'b0;
            m_eol_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
            end
            if (pop_d && complete_d) begin
                m_valid_q  <= 1'b1;
                m_data_q   <= beat_d;
                m_last_q   <= last_beat_d;
                m_eol_q    <= line_end_d;
                beat_cnt_q <= last_beat_d ? '0 : beat_cnt_q + BW'(1);
            end

            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        pix_cnt_q  <= '0;
                        line_cnt_q <= '0;
                        beat_cnt_q <= '0;
                        if (cfg_line_pixels == '0 || cfg_lines == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            line_pix_q <= cfg_line_pixels;
                            lines_q    <= cfg_lines;
                            state_q    <= RUN;
                            busy_q     <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (pop_d) begin
                        if (line_end_d) begin
                            pix_cnt_q  <= '0;
                            line_cnt_q <= line_cnt_q + CNT_WIDTH'(1);
                            if (last_line_d) begin
                                state_q <= FLUSH;
                            end
                        end else begin
                            pix_cnt_q <= pix_cnt_q + CNT_WIDTH'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (m_valid_q && m_ready) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef MIX_FIFO_RD_STAT_EN
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            stall_cnt <= '0;
        end else if (frame_start) begin
            stall_cnt <= '0;
        end else if (busy_q && m_valid_q && !m_ready && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

    assign fifo_rd_en = pop_d;
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_last     = m_last_q;
    assign m_eol      = m_eol_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_mix_fifo_burst_reader.sv
// tb/tb_mix_fifo_burst_reader.sv - randomized bench against a frame-level beat model
module tb_mix_fifo_burst_reader;

    localparam int IW = 16;
    localparam int OW = 64;
    localparam int BL = 16;
    localparam int CW = 12;
    localparam int PK = OW / IW;

    logic          rd_clk = 1'b0;
    logic          rd_rst;
    logic          frame_start;
    logic [CW-1:0] cfg_line_pixels;
    logic [CW-1:0] cfg_lines;
    logic          fifo_rd_vld;
    logic [IW-1:0] fifo_rd_data;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready;
    logic [OW-1:0] m_data;
    logic          m_last;
    logic          m_eol;
    logic          busy;
    logic          done;

    typedef struct {
        logic [OW-1:0] data;
        logic          last;
        logic          eol;
    } beat_t;

    logic [IW-1:0] pix_q[$];
    beat_t         exp_q[$];

    int checks   = 0;
    int failures = 0;

    always #5 rd_clk = ~rd_clk;

    mix_fifo_burst_reader #(
        .IN_DATA_WIDTH  (IW),
        .OUT_DATA_WIDTH (OW),
        .BURST_LEN      (BL),
        .CNT_WIDTH      (CW)
    ) dut (
        .rd_clk          (rd_clk),
        .rd_rst          (rd_rst),
        .frame_start     (frame_start),
        .cfg_line_pixels (cfg_line_pixels),
        .cfg_lines       (cfg_lines),
        .fifo_rd_vld     (fifo_rd_vld),
        .fifo_rd_data    (fifo_rd_data),
        .fifo_rd_en      (fifo_rd_en),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_data          (m_data),
        .m_last          (m_last),
        .m_eol           (m_eol),
        .busy            (busy),
        .done            (done)
    );

    task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit completes(input int idx, input int lp);
        int p;
        if (lp <= 0) return 1'b0;
        p = idx % lp;
        return (p % PK == PK - 1) || (p == lp - 1);
    endfunction

    // Whole frame expressed as a list of beats: chunk each line into PACK pixels, bursts cut at BL or line end.
    task automatic build_model(input int lp, input int nl);
        int            bc;
        logic [OW-1:0] acc;
        logic [IW-1:0] px;
        beat_t         b;
        bc  = 0;
        acc = '0;
        pix_q.delete();
        exp_q.delete();
        for (int l = 0; l < nl; l++) begin
            for (int p = 0; p < lp; p++) begin
                px = IW'($urandom);
                pix_q.push_back(px);
                acc[(p % PK)*IW +: IW] = px;
                if (p % PK == PK - 1 || p == lp - 1) begin
                    b.data = acc;
                    b.eol  = (p == lp - 1);
                    b.last = b.eol || (bc == BL - 1);
                    bc     = b.last ? 0 : bc + 1;
                    exp_q.push_back(b);
                    acc = '0;
                end
            end
        end
    endtask

    task automatic start_frame(input int lp, input int nl);
        @(negedge rd_clk);
        frame_start     = 1'b1;
        cfg_line_pixels = CW'(lp);
        cfg_lines       = CW'(nl);
        fifo_rd_vld     = 1'b0;
        m_ready         = 1'b1;
    endtask

    // vmode: 0 always valid, 1 toggling, 2 random. rmode: 0 always ready, 1 random, 2 low 10 cycles from stall_at.
    task automatic run_frame(input int lp, input int nl, input int vmode, input int rmode, input int stall_at);
        int            popped;
        int            total;
        bit            active;
        bit            done_exp;
        bit            done_next;
        bit            lat_pend;
        bit            hold;
        bit            fin;
        bit            exp_en;
        logic [OW-1:0] hd;
        logic          hl;
        logic          he;
        beat_t         b;
        popped   = 0;
        total    = lp * nl;
        active   = (total != 0);
        done_exp = (total == 0);
        lat_pend = 1'b0;
        hold     = 1'b0;
        fin      = 1'b0;
        hd       = '0;
        hl       = 1'b0;
        he       = 1'b0;
        build_model(lp, nl);
        start_frame(lp, nl);
        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(negedge rd_clk);
            frame_start = 1'b0;
            check("done", done, done_exp);
            check("busy", busy, active);
            if (done_exp) begin
                fin = 1'b1;
                break;
            end
            if (hold) begin
                check("hold_data", m_data, hd);
                check("hold_last", m_last, hl);
                check("hold_eol", m_eol, he);
            end
            if (lat_pend) check("latency", m_valid, 1'b1);
            case (vmode)
                0:       fifo_rd_vld = 1'b1;
                1:       fifo_rd_vld = (cyc % 2 == 0);
                default: fifo_rd_vld = ($urandom_range(0, 3) != 0);
            endcase
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = ($urandom_range(0, 2) != 0);
                default: m_ready = !(cyc >= stall_at && cyc < stall_at + 10);
            endcase
            fifo_rd_data = (popped < total) ? pix_q[popped] : IW'($urandom);
            #1;
            exp_en = active && (popped < total) && fifo_rd_vld &&
                     (!completes(popped, lp) || !m_valid || m_ready);
            check("rd_en", fifo_rd_en, exp_en);
            done_next = 1'b0;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 1'b1, 1'b0);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_data", m_data, b.data);
                    check("beat_last", m_last, b.last);
                    check("beat_eol", m_eol, b.eol);
                    if (exp_q.size() == 0) begin
                        done_next = 1'b1;
                        active    = 1'b0;
                    end
                end
            end
            lat_pend = 1'b0;
            if (fifo_rd_en) begin
                lat_pend = completes(popped, lp);
                popped++;
            end
            hold     = m_valid && !m_ready;
            hd       = m_data;
            hl       = m_last;
            he       = m_eol;
            done_exp = done_next;
        end
        if (!fin) check("timeout", 1'b0, 1'b1);
        check("beats_left", exp_q.size(), 0);
        check("pixels_left", total - popped, 0);
        @(negedge rd_clk);
        check("done_single", done, 1'b0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd_en"}, fifo_rd_en, 1'b0);
        check({tag, "_valid"}, m_valid, 1'b0);
        check({tag, "_data"}, m_data, '0);
        check({tag, "_last"}, m_last, 1'b0);
        check({tag, "_eol"}, m_eol, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
    endtask

    task automatic reset_mid_frame();
        int popped;
        bit reached;
        popped  = 0;
        reached = 1'b0;
        build_model(8, 2);
        start_frame(8, 2);
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge rd_clk);
            frame_start  = 1'b0;
            fifo_rd_vld  = 1'b1;
            m_ready      = 1'b1;
            fifo_rd_data = pix_q[popped];
            #1;
            if (fifo_rd_en) popped++;
            if (popped == 5) begin
                reached = 1'b1;
                break;
            end
        end
        check("rst_reach5", reached, 1'b1);
        @(negedge rd_clk);
        rd_rst = 1'b1;
        @(negedge rd_clk);
        #1;
        check_idle_outputs("midrst");
        rd_rst      = 1'b0;
        fifo_rd_vld = 1'b0;
    endtask

    initial begin
        rd_rst          = 1'b1;
        frame_start     = 1'b0;
        cfg_line_pixels = '0;
        cfg_lines       = '0;
        fifo_rd_vld     = 1'b1;
        fifo_rd_data    = '0;
        m_ready         = 1'b0;
        repeat (3) @(negedge rd_clk);
        #1;
        check_idle_outputs("reset");
        rd_rst      = 1'b0;
        fifo_rd_vld = 1'b0;

        run_frame(8, 2, 0, 0, 0);
        run_frame(6, 1, 0, 0, 0);
        run_frame(160, 1, 0, 0, 0);
        run_frame(8, 4, 0, 2, 5);
        run_frame(8, 1, 1, 0, 0);
        run_frame(0, 3, 0, 0, 0);
        run_frame(5, 0, 0, 0, 0);
        reset_mid_frame();
        run_frame(4, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            run_frame($urandom_range(1, 40), $urandom_range(1, 4), 2, 1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
